// File: rtl/caslock_pkg.sv
// Shared types and helpers for the CAS-Lock key loader.
package caslock_pkg;

    // Width of the byte checksum that trails the key in the serial stream.
    localparam int CKSUM_W = 8;

    // Widest key the checksum helper can fold. The loader's KEY_W must not exceed this.
    localparam int KEY_W_MAX = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_ARMED   = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } caslock_state_e;

    // XOR of the key bytes, where byte j is key[8j+7:8j]. Only the lowest
    // n_bytes bytes take part, so a narrower key can be zero-extended into
    // the argument.
    function automatic logic [CKSUM_W-1:0] key_cksum(input logic [KEY_W_MAX-1:0] key,
                                                     input int n_bytes = KEY_W_MAX / 8);
        logic [CKSUM_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < KEY_W_MAX / 8; j++) begin
            if (j < n_bytes) begin
                acc = acc ^ key[8*j +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/caslock_shift_rx.sv
// Serial receiver for the key loader. It deserialises KEY_W key bits and then
// CKSUM_W checksum bits, LSB first, into shadow registers.
//
// Handshake: a bit is transferred on a rising edge where ser_valid_i and
// ser_ready_o are both high. ser_ready_o is a registered flag and never
// depends on ser_valid_i in the same cycle. ser_valid_i low simply stalls,
// with no timeout.
module caslock_shift_rx
    import caslock_pkg::*;
#(
    parameter int KEY_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               ser_valid_i,
    input  logic               ser_data_i,
    output logic               ser_ready_o,
    output logic               done_o,
    output logic [KEY_W-1:0]   shadow_o,
    output logic [CKSUM_W-1:0] cksum_o
);

    localparam int NBITS = KEY_W + CKSUM_W;
    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    logic [CNT_W-1:0]   cnt_q;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [CKSUM_W-1:0] cksum_q, cksum_d;
    logic               ready_q;
    logic               done_q;
    logic               accept;
    logic               last_bit;

    assign accept   = ser_valid_i & ready_q;
    assign last_bit = (cnt_q == LAST_IDX);

    // Write the accepted bit into the shadow slot selected by the bit counter.
    always_comb begin
        shadow_d = shadow_q;
        cksum_d  = cksum_q;
        if (start_i) begin
            shadow_d = '0;
            cksum_d  = '0;
        end else if (accept) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    shadow_d[i] = ser_data_i;
                end
            end
            for (int i = 0; i < CKSUM_W; i++) begin
                if (cnt_q == CNT_W'(KEY_W + i)) begin
                    cksum_d[i] = ser_data_i;
                end
            end
        end
    end

    // Counter, ready flag and a one-cycle done pulse after the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            cksum_q  <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cksum_q  <= cksum_d;
            if (start_i) begin
                cnt_q   <= '0;
                ready_q <= 1'b1;
                done_q  <= 1'b0;
            end else begin
                done_q <= accept & last_bit;
                if (accept) begin
                    if (last_bit) begin
                        ready_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign ser_ready_o = ready_q;
    assign done_o      = done_q;
    assign shadow_o    = shadow_q;
    assign cksum_o     = cksum_q;

endmodule

// File: rtl/caslock_key_loader.sv
// Key-delivery stage in front of the CAS-Lock locked netlist. It receives the
// key serially, verifies the byte checksum and only then releases the key on
// key_out. Any reload zeroes key_out first, and MAX_TRIES failed checks lock the
// loader until reset. KEY_W must be a multiple of 8 and no larger than
// KEY_W_MAX.
module caslock_key_loader
    import caslock_pkg::*;
#(
    parameter int KEY_W     = 64,
    parameter int MAX_TRIES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_start,
    input  logic           ser_valid,
    input  logic           ser_data,
    output logic           ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic           key_valid,
    output logic           key_err,
    output logic           locked,
    output logic           busy,
    output caslock_state_e state_dbg
);

    caslock_state_e     state_q;
    logic [KEY_W-1:0]   key_q;
    logic               key_valid_q;
    logic               key_err_q;
    logic               locked_q;
    logic               busy_q;
    logic [3:0]         fail_cnt_q;
    logic [3:0]         fail_cnt_d;

    logic               rx_start;
    logic               rx_done;
    logic [KEY_W-1:0]   rx_shadow;
    logic [CKSUM_W-1:0] rx_cksum;
    logic               cksum_ok;

    // load_start only takes effect from a resting state; LOAD, CHECK and LOCKOUT ignore it.
    always_comb begin
        rx_start = 1'b0;
        if (load_start && (state_q == ST_IDLE || state_q == ST_ARMED || state_q == ST_ERROR)) begin
            rx_start = 1'b1;
        end
    end

    assign fail_cnt_d = fail_cnt_q + 4'd1;
    assign cksum_ok   = (key_cksum(KEY_W_MAX'(rx_shadow), KEY_W / 8) == rx_cksum);

    caslock_shift_rx #(
        .KEY_W(KEY_W)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (rx_start),
        .ser_valid_i(ser_valid),
        .ser_data_i (ser_data),
        .ser_ready_o(ser_ready),
        .done_o     (rx_done),
        .shadow_o   (rx_shadow),
        .cksum_o    (rx_cksum)
    );

    // Control FSM with registered outputs. key_q changes only on entry to LOAD (to 0) or ARMED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ARMED, ST_ERROR: begin
                    if (rx_start) begin
                        state_q     <= ST_LOAD;
                        key_q       <= '0;
                        key_valid_q <= 1'b0;
                        key_err_q   <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (rx_done) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    busy_q <= 1'b0;
                    if (cksum_ok) begin
                        state_q     <= ST_ARMED;
                        key_q       <= rx_shadow;
                        key_valid_q <= 1'b1;
                    end else begin
                        // The fail count survives successful loads; only reset clears it.
                        fail_cnt_q <= fail_cnt_d;
                        key_err_q  <= 1'b1;
                        if (fail_cnt_d == 4'(MAX_TRIES)) begin
                            state_q  <= ST_LOCKOUT;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    state_q <= ST_LOCKOUT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign locked    = locked_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_caslock_key_loader.sv
// Directed bench for caslock_key_loader: good load, bad load and retry,
// stalled load, reload with mid-load reset, and lockout after three failures.
module tb_caslock_key_loader;
    import caslock_pkg::*;

    localparam int KEY_W     = 64;
    localparam int MAX_TRIES = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_start = 1'b0;
    logic             ser_valid = 1'b0;
    logic             ser_data = 1'b0;
    logic             ser_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_err;
    logic             locked;
    logic             busy;
    caslock_state_e   state_dbg;

    int total = 0;
    int bad   = 0;

    caslock_key_loader #(
        .KEY_W    (KEY_W),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_start(load_start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_err   (key_err),
        .locked    (locked),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Offer one bit after `stall` idle cycles; returns just after the accepting edge.
    task automatic send_bit(input logic b, input int stall);
        int n;
        for (int s = 0; s < stall; s++) begin
            ser_valid = 1'b0;
            ser_data  = 1'($urandom_range(0, 1));
            step();
        end
        ser_valid = 1'b1;
        ser_data  = b;
        n = 0;
        while (ser_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 64'(ser_ready), 64'd1);
        end
        step();
        ser_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [63:0] key, input logic [7:0] ck,
                               input int max_stall, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < KEY_W) ? key[i] : ck[i-KEY_W], int'($urandom_range(0, max_stall)));
        end
    endtask

    // Called right after the final bit is accepted (edge M): results appear at edge M+2.
    task automatic check_result(input string tag, input logic [63:0] exp_key, input logic exp_valid,
                                input logic exp_err, input logic exp_locked,
                                input caslock_state_e exp_state);
        chk({tag, "_valid_m1"}, 64'(key_valid), 64'd0);
        chk({tag, "_ready_m1"}, 64'(ser_ready), 64'd0);
        step();
        chk({tag, "_state_chk"}, 64'(state_dbg), 64'(ST_CHECK));
        chk({tag, "_busy_chk"}, 64'(busy), 64'd1);
        chk({tag, "_key_chk"}, key_out, 64'd0);
        step();
        chk({tag, "_key"}, key_out, exp_key);
        chk({tag, "_valid"}, 64'(key_valid), 64'(exp_valid));
        chk({tag, "_err"}, 64'(key_err), 64'(exp_err));
        chk({tag, "_locked"}, 64'(locked), 64'(exp_locked));
        chk({tag, "_state"}, 64'(state_dbg), 64'(exp_state));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] key_a;
        logic [63:0] key_b;
        logic [63:0] key_c;
        key_a = 64'h0123_4567_89AB_CDEF;
        key_b = 64'hFFFF_FFFF_0000_0000;
        key_c = 64'hA5A5_A5A5_A5A5_A5A5;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_key", key_out, 64'd0);
        chk("rst_valid", 64'(key_valid), 64'd0);
        chk("rst_err", 64'(key_err), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(ser_ready), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));

        // Good key, checksum 0x00, no stalls
        pulse_start();
        chk("t1_ready", 64'(ser_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_state", 64'(state_dbg), 64'(ST_LOAD));
        send_stream(key_a, 8'h00, 0, 72);
        check_result("t1", key_a, 1'b1, 1'b0, 1'b0, ST_ARMED);

        // Same key, wrong checksum 0x01, then a correct reload
        pulse_start();
        chk("t2_key_cleared", key_out, 64'd0);
        chk("t2_valid_cleared", 64'(key_valid), 64'd0);
        send_stream(key_a, 8'h01, 0, 72);
        check_result("t2_bad", 64'd0, 1'b0, 1'b1, 1'b0, ST_ERROR);
        pulse_start();
        chk("t2_err_cleared", 64'(key_err), 64'd0);
        send_stream(key_a, 8'h00, 0, 72);
        check_result("t2_retry", key_a, 1'b1, 1'b0, 1'b0, ST_ARMED);

        // load_start in LOAD is ignored; random stalls of 0..5 cycles
        pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("t3_start_in_load", 64'(state_dbg), 64'(ST_LOAD));
        send_stream(key_b, 8'h00, 5, 72);
        check_result("t3_stall", key_b, 1'b1, 1'b0, 1'b0, ST_ARMED);

        // Reload from ARMED, reset after 30 bits
        pulse_start();
        chk("t4_key_zero", key_out, 64'd0);
        chk("t4_valid_zero", 64'(key_valid), 64'd0);
        send_stream(key_a, 8'h00, 0, 30);
        chk("t4_busy_mid", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_key", key_out, 64'd0);
        chk("t4_rst_valid", 64'(key_valid), 64'd0);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        chk("t4_rst_ready", 64'(ser_ready), 64'd0);
        chk("t4_rst_state", 64'(state_dbg), 64'(ST_IDLE));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        pulse_start();
        send_stream(key_c, 8'h00, 0, 72);
        check_result("t4_a5", key_c, 1'b1, 1'b0, 1'b0, ST_ARMED);

        // Three bad loads lock the loader (fail count restarted by the reset above)
        pulse_start();
        send_stream(key_a, 8'hFF, 0, 72);
        check_result("t5_bad1", 64'd0, 1'b0, 1'b1, 1'b0, ST_ERROR);
        pulse_start();
        send_stream(key_b, 8'h01, 0, 72);
        check_result("t5_bad2", 64'd0, 1'b0, 1'b1, 1'b0, ST_ERROR);
        pulse_start();
        send_stream(key_c, 8'h5A, 0, 72);
        check_result("t5_bad3", 64'd0, 1'b0, 1'b1, 1'b1, ST_LOCKOUT);
        pulse_start();
        step();
        chk("t5_lock_ready", 64'(ser_ready), 64'd0);
        chk("t5_lock_key", key_out, 64'd0);
        chk("t5_lock_state", 64'(state_dbg), 64'(ST_LOCKOUT));
        chk("t5_lock_busy", 64'(busy), 64'd0);
        chk("t5_lock_locked", 64'(locked), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
